// File: rtl/us_echo_responder.sv
// us_echo_responder: ultrasonic ranging sensor emulator; answers a valid trigger
// with a delayed echo pulse whose width encodes the emulated target distance.
module us_echo_responder #(
    parameter int TRIG_MIN_CYC    = 500,
    parameter int BURST_DELAY_CYC = 10000,
    parameter int CYC_PER_MM      = 290,
    parameter int TIMEOUT_CYC     = 1900000,
    parameter int HOLDOFF_CYC     = 500
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distance_mm,
    output logic        echo_rx,
    output logic        trig_err,
    output logic        busy,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;
    state_t      state_q, state_d;
    logic [21:0] cnt_q, cnt_d, len_q, len_d, prod;
    logic        trig_d_q, echo_q, echo_d, err_q, err_d, rise;
    assign rise = trigger & ~trig_d_q;
    assign prod = {10'd0, distance_mm} * 22'(CYC_PER_MM);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        echo_d  = echo_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (rise) begin
                state_d = TRIG_HI;
                cnt_d   = 22'd1;
            end
            TRIG_HI: if (trigger) begin
                cnt_d = (cnt_q >= 22'(TRIG_MIN_CYC)) ? cnt_q : cnt_q + 22'd1;
            end else if (cnt_q >= 22'(TRIG_MIN_CYC)) begin
                state_d = BURST;
                cnt_d   = 22'd1;
                // Echo length is frozen here so later distance changes cannot disturb it
                len_d   = (distance_mm == 12'd0 || distance_mm > 12'd4000) ? 22'(TIMEOUT_CYC) :
                          (distance_mm < 12'd20) ? 22'(20 * CYC_PER_MM) : prod;
            end else begin
                state_d = IDLE;
                cnt_d   = 22'd0;
                err_d   = 1'b1;
            end
            BURST: if (cnt_q == 22'(BURST_DELAY_CYC)) begin
                state_d = ECHO;
                cnt_d   = 22'd1;
                echo_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 22'd1;
            end
            ECHO: if (cnt_q == len_q) begin
                state_d = HOLDOFF;
                cnt_d   = 22'd1;
                echo_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 22'd1;
            end
            HOLDOFF: if (cnt_q == 22'(HOLDOFF_CYC)) begin
                state_d = IDLE;
                cnt_d   = 22'd0;
            end else begin
                cnt_d = cnt_q + 22'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 22'd0;
                echo_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            echo_q   <= 1'b0;
            err_q    <= 1'b0;
            trig_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            echo_q   <= echo_d;
            err_q    <= err_d;
            trig_d_q <= trigger;
        end
    end
    assign echo_rx  = echo_q;
    assign trig_err = err_q;
    assign busy     = (state_q != IDLE);
    assign state    = state_q;
endmodule
